// File: rtl/pu_msp430_per_arbiter.sv
// pu_msp430_per_arbiter: two-master MSP430 peripheral bus arbiter with registered grant, burst limit and lock.
// Define PU_MSP430_PER_ARB_FIXED_PRIO_EN for fixed master-0 priority (burst limit on master 1 only).
module pu_msp430_per_arbiter #(
  parameter int MAX_BURST = 4,
  parameter int BURST_WD  = 4
) (
  input  logic        mclk,
  input  logic        puc_rst_n,
  input  logic        m0_req,
  input  logic        m0_lock,
  input  logic [13:0] m0_addr,
  input  logic [15:0] m0_din,
  input  logic [1:0]  m0_we,
  output logic        m0_gnt,
  output logic [15:0] m0_dout,
  input  logic        m1_req,
  input  logic        m1_lock,
  input  logic [13:0] m1_addr,
  input  logic [15:0] m1_din,
  input  logic [1:0]  m1_we,
  output logic        m1_gnt,
  output logic [15:0] m1_dout,
  output logic [13:0] per_addr,
  output logic [15:0] per_din,
  output logic        per_en,
  output logic [1:0]  per_we,
  input  logic [15:0] per_dout
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  localparam logic [BURST_WD-1:0] BURST_MAX = BURST_WD'(MAX_BURST);
  localparam logic [BURST_WD-1:0] BURST_LIM = BURST_WD'(MAX_BURST - 1);
  state_t state, state_nxt;
  logic [BURST_WD-1:0] cnt, cnt_nxt;
  logic last, last_nxt, own0, own1, own_req, oth_req, own_lock, keep, tie_own0;
  always_comb begin
    own0 = state == OWN0;
    own1 = state == OWN1;
    own_req = own1 ? m1_req : m0_req;
    oth_req = own1 ? m0_req : m1_req;
    own_lock = own1 ? m1_lock : m0_lock;
`ifdef PU_MSP430_PER_ARB_FIXED_PRIO_EN
    tie_own0 = 1'b1;
    keep = own_req & (own0 | ~oth_req | own_lock | (cnt < BURST_LIM));
`else
    tie_own0 = last;
    keep = own_req & (~oth_req | own_lock | (cnt < BURST_LIM));
`endif
    // an owner that loses keep while requesting always has a requesting rival
    state_nxt = own0 ? (keep ? OWN0 : m1_req ? OWN1 : IDLE) :
                own1 ? (keep ? OWN1 : m0_req ? OWN0 : IDLE) :
                (m0_req & m1_req) ? (tie_own0 ? OWN0 : OWN1) :
                m0_req ? OWN0 : m1_req ? OWN1 : IDLE;
    cnt_nxt = (state_nxt != state || state == IDLE) ? '0 :
              (cnt == BURST_MAX) ? cnt : cnt + 1'b1;
    last_nxt = (state_nxt == OWN0) ? 1'b0 : (state_nxt == OWN1) ? 1'b1 : last;
  end
  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      last  <= last_nxt;
    end
  end
  always_comb begin
    m0_gnt   = own0;
    m1_gnt   = own1;
    per_en   = own0 | own1;
    per_addr = own0 ? m0_addr : own1 ? m1_addr : '0;
    per_din  = own0 ? m0_din : own1 ? m1_din : '0;
    per_we   = own0 ? m0_we : own1 ? m1_we : '0;
    m0_dout  = (own0 && m0_we == 2'b00) ? per_dout : '0;
    m1_dout  = (own1 && m1_we == 2'b00) ? per_dout : '0;
  end
endmodule

// File: tb/tb_pu_msp430_per_arbiter.sv
// tb_pu_msp430_per_arbiter: scoreboard bench; a grant-count reference model predicts each bus cycle.
module tb_pu_msp430_per_arbiter;
  localparam int MAX_BURST = 4;
  typedef struct packed {
    logic g0, g1, en;
    logic [13:0] addr;
    logic [15:0] din;
    logic [1:0] we;
    logic [15:0] d0, d1;
  } obs_t;
  logic mclk, puc_rst_n;
  logic req[2], lock[2];
  logic [13:0] addr[2];
  logic [15:0] din[2];
  logic [1:0] we[2];
  logic [15:0] per_dout;
  logic m0_gnt, m1_gnt, per_en;
  logic [15:0] m0_dout, m1_dout, per_din;
  logic [13:0] per_addr;
  logic [1:0] per_we;
  int checks = 0, errors = 0;
  int m_owner, m_tenure, m_last;
  obs_t expq[$];
  pu_msp430_per_arbiter #(.MAX_BURST(MAX_BURST), .BURST_WD(4)) dut (
    .mclk(mclk), .puc_rst_n(puc_rst_n),
    .m0_req(req[0]), .m0_lock(lock[0]), .m0_addr(addr[0]), .m0_din(din[0]), .m0_we(we[0]),
    .m0_gnt(m0_gnt), .m0_dout(m0_dout),
    .m1_req(req[1]), .m1_lock(lock[1]), .m1_addr(addr[1]), .m1_din(din[1]), .m1_we(we[1]),
    .m1_gnt(m1_gnt), .m1_dout(m1_dout),
    .per_addr(per_addr), .per_din(per_din), .per_en(per_en), .per_we(per_we),
    .per_dout(per_dout)
  );
  initial mclk = 1'b0;
  always #5 mclk = ~mclk;
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask
  task automatic model_reset();
    m_owner = -1;
    m_tenure = 0;
    m_last = 1;
  endtask
  // m_tenure counts grants in the current ownership, including the one being decided
  task automatic model_step();
    int nxt, oth;
    if (m_owner < 0) begin
`ifdef PU_MSP430_PER_ARB_FIXED_PRIO_EN
      if (req[0] && req[1]) nxt = 0;
`else
      if (req[0] && req[1]) nxt = 1 - m_last;
`endif
      else nxt = req[0] ? 0 : req[1] ? 1 : -1;
    end else begin
      oth = 1 - m_owner;
      if (!req[m_owner]) nxt = req[oth] ? oth : -1;
      else if (!req[oth] || lock[m_owner]) nxt = m_owner;
`ifdef PU_MSP430_PER_ARB_FIXED_PRIO_EN
      else if (m_owner == 0) nxt = 0;
`endif
      else nxt = (m_tenure < MAX_BURST) ? m_owner : oth;
    end
    m_tenure = (nxt < 0) ? 0 : (nxt == m_owner) ? m_tenure + 1 : 1;
    if (nxt >= 0) m_last = nxt;
    m_owner = nxt;
  endtask
  function automatic obs_t expect_now();
    obs_t e;
    e = '0;
    if (m_owner >= 0) begin
      e.g0 = m_owner == 0;
      e.g1 = m_owner == 1;
      e.en = 1'b1;
      e.addr = addr[m_owner];
      e.din = din[m_owner];
      e.we = we[m_owner];
      if (we[m_owner] == 2'b00) begin
        if (m_owner == 0) e.d0 = per_dout;
        else e.d1 = per_dout;
      end
    end
    return e;
  endfunction
  // called at a falling edge with inputs set; returns at the next falling edge
  task automatic step();
    model_step();
    expq.push_back(expect_now());
    @(negedge mclk);
  endtask
  task automatic do_reset();
    puc_rst_n = 1'b0;
    @(negedge mclk);
    puc_rst_n = 1'b1;
    model_reset();
  endtask
  always @(posedge mclk) begin
    obs_t got, exp;
    #1;
    if (expq.size() > 0) begin
      exp = expq.pop_front();
      got = '{m0_gnt, m1_gnt, per_en, per_addr, per_din, per_we, m0_dout, m1_dout};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL bus t=%0t got %h exp %h", $time, got, exp);
      end
    end
  end
  initial begin
    int pat[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    puc_rst_n = 1'b0;
    for (int m = 0; m < 2; m++) begin
      req[m] = 0; lock[m] = 0; addr[m] = '0; din[m] = '0; we[m] = '0;
    end
    per_dout = 16'hFFFF;
    model_reset();
    @(negedge mclk);
    @(negedge mclk);
    chk("reset_gnt", 32'({m0_gnt, m1_gnt, per_en}), 32'd0);
    chk("reset_bus", 32'({per_addr, per_we}), 32'd0);
    chk("reset_din", 32'(per_din), 32'd0);
    chk("reset_dout", {m0_dout, m1_dout}, 32'd0);
    puc_rst_n = 1'b1;
    req[0] = 1; addr[0] = 14'h0048; we[0] = 2'b00; per_dout = 16'h00A5;
    chk("no_same_cycle_gnt", 32'(m0_gnt), 32'd0);
    step();
    chk("first_gnt", 32'({m0_gnt, per_en}), 32'h3);
    chk("first_addr", 32'(per_addr), 32'h0048);
    chk("first_rd", 32'(m0_dout), 32'h00A5);
    chk("first_m1_dout", 32'(m1_dout), 32'd0);
    req[0] = 0;
    step();
    do_reset();
    req[0] = 1; req[1] = 1; addr[0] = 14'h0010; addr[1] = 14'h0020; per_dout = 16'h5A5A;
    for (int i = 0; i < 9; i++) begin
      step();
      chk("burst_pattern", 32'({m1_gnt, m0_gnt}), pat[i] ? 32'h2 : 32'h1);
    end
    req[0] = 0; req[1] = 0;
    step();
    req[1] = 1; we[1] = 2'b01; din[1] = 16'h1234; addr[1] = 14'h0049; per_dout = 16'hABCD;
    step();
    chk("wr_we", 32'(per_we), 32'h1);
    chk("wr_din", 32'(per_din), 32'h1234);
    chk("wr_dout", 32'(m1_dout), 32'd0);
    req[1] = 0;
    step();
    chk("wr_one_cycle", 32'({per_en, per_we}), 32'd0);
    req[0] = 1; lock[0] = 1; addr[0] = 14'h0048;
    step();
    req[1] = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("lock_hold", 32'({m1_gnt, m0_gnt}), 32'h1);
    end
    lock[0] = 0;
    step();
    chk("unlock_switch", 32'(m1_gnt), 32'd1);
    step();
    chk("m1_burst", 32'(m1_gnt), 32'd1);
    #2 puc_rst_n = 1'b0;
    #1 chk("async_rst", 32'({m1_gnt, per_en, per_we}), 32'd0);
    @(negedge mclk);
    puc_rst_n = 1'b1;
    model_reset();
    step();
    chk("post_rst_m0", 32'({m1_gnt, m0_gnt}), 32'h1);
`ifdef PU_MSP430_PER_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 20; i++) begin
      step();
      chk("fixed_prio", 32'(m1_gnt), 32'd0);
    end
`endif
    for (int n = 0; n < 3000; n++) begin
      for (int m = 0; m < 2; m++) begin
        if (!req[m]) begin
          if ($urandom_range(0, 2) == 0) begin
            req[m] = 1;
            addr[m] = 14'($urandom);
            din[m] = 16'($urandom);
            we[m] = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
          end
        end else if (m_owner == m && $urandom_range(0, 3) == 0) req[m] = 0;
        lock[m] = ($urandom_range(0, 4) == 0);
      end
      per_dout = 16'($urandom);
      if ($urandom_range(0, 199) == 0) do_reset();
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
